// File: rtl/alu_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md_pkg : op codes, FSM states and MD-op decode for alu_md        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_md_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_BUSY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // MULT/MULTU/DIV/DIVU occupy 10xx
    function automatic logic OP_IS_MD(input logic [3:0] op);
        return op[3] && !op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit : iterative shift-add multiply / restoring divide            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_r;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign sa    = signed_op && a[WIDTH-1];
    assign sb    = signed_op && b[WIDTH-1];
    assign mag_a = sa ? (~a + 1'b1) : a;
    assign mag_b = sb ? (~b + 1'b1) : b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // One iteration; the final iteration's value feeds the sign fix-up directly
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, mcand});
        div_diff = div_sh[WIDTH-1:0] - mcand;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        prod_fix = neg_q ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
        q_fix    = neg_q ? (~step_lo + 1'b1) : step_lo;
        r_fix    = neg_r ? (~step_hi + 1'b1) : step_hi;
        if (is_div) begin
            hi = r_fix;
            lo = dbz_r ? '1 : q_fix;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

    assign done = busy && (cnt == '0);
    assign dbz  = dbz_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz_r  <= 1'b0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            is_div <= div_op;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dbz_r  <= div_op && (b == '0);
            mcand  <= div_op ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= div_op ? mag_a : mag_b;
        end else if (busy) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_md : EX-stage ALU with iterative multiply/divide and HI/LO       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div_by_zero
);

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_dbz;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_ONE) || (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && OP_IS_MD(op);

    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .div_op    (op[1]),
        .signed_op (!op[0]),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo),
        .dbz       (md_dbz)
    );

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            result      <= '0;
            zero        <= 1'b1;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (OP_IS_MD(op)) begin
                            state <= S_BUSY;
                        end else begin
                            state       <= S_ONE;
                            result      <= alu_res;
                            zero        <= (alu_res == '0);
                            ovf         <= alu_ovf;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    // HI/LO land together with the result so an MFHI/MFLO right after DONE sees them
                    if (md_done) begin
                        state       <= S_DONE;
                        hi          <= md_hi;
                        lo          <= md_lo;
                        result      <= md_lo;
                        zero        <= (md_lo == '0);
                        ovf         <= 1'b0;
                        div_by_zero <= md_dbz;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_md : randomized + directed bench for alu_md (WIDTH = 32)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_md;
    import alu_md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_md #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .result      (result),
        .zero        (zero),
        .ovf         (ovf),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
        logic         dbz;
        logic         md;
    } mres_t;

    function automatic mres_t ref_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] h, input logic [W-1:0] l);
        mres_t r;
        int sx, sy;
        longint p;
        longint unsigned pu;
        sx = x;
        sy = y;
        r = '0;
        r.hi = h;
        r.lo = l;
        r.md = (o >= 4'd8) && (o <= 4'd11);
        case (o)
            4'd0: r.res = x & y;
            4'd1: r.res = x | y;
            4'd2: begin
                r.res = x + y;
                r.ovf = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            4'd3: r.res = x ^ y;
            4'd4: r.res = ~(x | y);
            4'd5: r.res = (x < y) ? 1 : 0;
            4'd6: begin
                r.res = x - y;
                r.ovf = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            4'd7: r.res = (sx < sy) ? 1 : 0;
            4'd8: begin
                p = longint'(sx) * longint'(sy);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            4'd9: begin
                pu = {32'd0, x} * {32'd0, y};
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            4'd10: begin
                if (y == 0) begin
                    r.hi = x; r.lo = '1; r.dbz = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r.hi = 0; r.lo = x;
                end else begin
                    r.lo = sx / sy;
                    r.hi = sx % sy;
                end
            end
            4'd11: begin
                if (y == 0) begin
                    r.hi = x; r.lo = '1; r.dbz = 1'b1;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
            4'd12: r.res = h;
            4'd13: r.res = l;
            default: r.res = 0;
        endcase
        if (r.md) r.res = r.lo;
        return r;
    endfunction

    // Schedule: one op in flight; outputs shown from the completion cycle on
    bit           pend = 1'b0;
    int           cyc = 0;
    int           done_cyc = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    mres_t        p_r = '0;
    logic [W-1:0] sh_res = '0;
    logic         sh_zero = 1'b1, sh_ovf = 1'b0, sh_dbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0; cyc = 0; done_cyc = 0;
            m_hi = '0; m_lo = '0;
            sh_res = '0; sh_zero = 1'b1; sh_ovf = 1'b0; sh_dbz = 1'b0;
        end else begin
            if (in_valid && !(pend && cyc <= done_cyc)) begin
                p_r = ref_op(op, a, b, m_hi, m_lo);
                m_hi = p_r.hi;
                m_lo = p_r.lo;
                pend = 1'b1;
                done_cyc = cyc + 1 + (p_r.md ? W : 0);
            end
            cyc++;
            if (pend && cyc == done_cyc) begin
                sh_res = p_r.res; sh_zero = (p_r.res == 0);
                sh_ovf = p_r.ovf; sh_dbz = p_r.dbz;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, !(pend && cyc <= done_cyc));
        check("out_valid", out_valid, pend && cyc == done_cyc);
        check("result", result, sh_res);
        check("zero", zero, sh_zero);
        check("ovf", ovf, sh_ovf);
        check("div_by_zero", div_by_zero, sh_dbz);
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                         output logic [W-1:0] r, output logic z, output logic f_ovf,
                         output logic f_dbz, output int lat);
        bit acc = 0;
        bit rn;
        int i = 0;
        @(negedge clk); #1;
        in_valid = 1'b1; op = t_op; a = t_a; b = t_b;
        while (!acc && i < 200) begin
            rn = in_ready;
            @(posedge clk);
            if (rn) acc = 1;
            else begin @(negedge clk); #1; end
            i++;
        end
        r = '0; z = 0; f_ovf = 0; f_dbz = 0; lat = 0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept op=%h", t_op);
            in_valid = 1'b0;
        end else begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 200) begin
                @(negedge clk); #1;
                lat++;
            end
            if (!out_valid) begin
                checks++; errors++;
                $display("FAIL out_valid_timeout actual=%0d required=<200 op=%h", lat, t_op);
            end
            r = result; z = zero; f_ovf = ovf; f_dbz = div_by_zero;
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 0;
            1: v = 1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = $urandom_range(0, 15);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] r;
        logic z, fo, fd;
        int lat, n;

        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        rst_n = 1'b1;

        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, r, z, fo, fd, lat);
        check("add_res", r, 32'h8000_0000);
        check("add_ovf", fo, 1);
        check("add_lat", lat, 1);
        issue(OP_SUB, 32'd5, 32'd5, r, z, fo, fd, lat);
        check("sub_res", r, 0);
        check("sub_zero", z, 1);
        issue(OP_SLT, 32'h8000_0000, 32'd1, r, z, fo, fd, lat);
        check("slt_neg", r, 1);
        issue(OP_SLTU, 32'h8000_0000, 32'd1, r, z, fo, fd, lat);
        check("sltu_big", r, 0);
        issue(OP_SLT, 32'd3, 32'd3, r, z, fo, fd, lat);
        check("slt_eq", r, 0);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd7, r, z, fo, fd, lat);
        check("mult_lo", r, 32'hFFFF_FFF9);
        check("mult_lat", lat, 33);
        issue(OP_MFHI, 0, 0, r, z, fo, fd, lat);
        check("mult_hi", r, 32'hFFFF_FFFF);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd7, r, z, fo, fd, lat);
        check("multu_lo", r, 32'hFFFF_FFF9);
        issue(OP_MFHI, 0, 0, r, z, fo, fd, lat);
        check("multu_hi", r, 32'd6);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, z, fo, fd, lat);
        check("div_lo", r, 32'hFFFF_FFFD);
        issue(OP_MFHI, 0, 0, r, z, fo, fd, lat);
        check("div_hi", r, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'd7, 32'd0, r, z, fo, fd, lat);
        check("divu0_lo", r, 32'hFFFF_FFFF);
        check("divu0_dbz", fd, 1);
        check("divu0_lat", lat, 33);
        issue(OP_MFHI, 0, 0, r, z, fo, fd, lat);
        check("divu0_hi", r, 32'd7);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, z, fo, fd, lat);
        check("div_minneg_lo", r, 32'h8000_0000);
        check("div_minneg_dbz", fd, 0);
        issue(4'b1110, 32'd9, 32'd9, r, z, fo, fd, lat);
        check("op_e_res", r, 0);

        // Requests held high during BUSY must wait until the cycle after DONE
        @(negedge clk); #1;
        in_valid = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
        @(posedge clk);
        @(negedge clk); #1;
        op = OP_ADD; a = 32'd10; b = 32'd20;
        n = 1;
        while (!out_valid && n < 200) begin @(negedge clk); #1; n++; end
        check("hold_mult_lat", n, 33);
        check("hold_mult_res", result, 32'd15);
        @(negedge clk); #1;
        check("hold_idle_ready", in_ready, 1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        check("hold_add_valid", out_valid, 1);
        check("hold_add_res", result, 32'd30);

        // Reset in the middle of a multiply
        @(negedge clk); #1;
        in_valid = 1'b1; op = OP_MULT; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", in_ready, 1);
        check("midrst_valid", out_valid, 0);
        check("midrst_result", result, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        issue(OP_MFHI, 0, 0, r, z, fo, fd, lat);
        check("midrst_hi", r, 0);
        issue(OP_MFLO, 0, 0, r, z, fo, fd, lat);
        check("midrst_lo", r, 0);

        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), r, z, fo, fd, lat);
        end

        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_md.md
# alu_md

Parametrised successor to the datapath ALU. Registered single-cycle logic/arithmetic ops, corrected signed/unsigned set-less-than, and an iterative multiply/divide engine with architectural HI/LO registers. Sits in the EX stage behind a valid/ready handshake; the controller stalls while `in_ready` is low.

## Interface
- `WIDTH`, 32: operand/result width (≥4, even)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  high only in IDLE; a request is accepted when `in_valid && in_ready` at a rising edge
- `op`  in  4  operation code
- `a`, `b`  in  WIDTH  operands, sampled on accept
- `out_valid`  out  1  one-cycle pulse: `result` and flags are valid
- `result`  out  WIDTH  registered result
- `zero`  out  1  `result == 0`, registered with `result`
- `ovf`  out  1  signed overflow (ADD/SUB only; otherwise 0)
- `div_by_zero`  out  1  DIV/DIVU with `b == 0`; otherwise 0

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT, 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1100 MFHI, 1101 MFLO. Codes 1110/1111 yield `result` = 0 with a normal single-cycle pulse.
- ADD/SUB are modulo 2^WIDTH. `ovf` is set when the operand signs agree (ADD) or differ (SUB) and the result sign differs from `a`.
- SLT is a signed compare; SLTU is unsigned. Both return 1 or 0 zero-extended. Equal operands return 0.
- MULT/MULTU: full 2·WIDTH product. {HI,LO} = product; `result` = LO.
- DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the sign of `a`. Most-negative ÷ −1 gives LO = most-negative, HI = 0, no flag.
- Divide by zero: HI = `a`, LO = all ones, `div_by_zero` = 1; still takes the full latency.
- Engine: shift-add multiply and restoring divide on magnitudes, one bit per cycle. The sign fix-up is applied in the final cycle.
- MFHI/MFLO return HI/LO. HI/LO change only when a MULT/DIV completes.
- FSM states:
  - IDLE → ONE on accept of a non-MD op.
  - IDLE → BUSY on accept of a MD op; the iteration counter loads WIDTH−1.
  - BUSY → DONE when the counter reaches 0.
  - ONE → IDLE and DONE → IDLE unconditionally.
  - `out_valid` = 1 in ONE and DONE only.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state IDLE; `in_ready` 1
  - `out_valid` 0, `result` 0, `zero` 1, `ovf` 0, `div_by_zero` 0
  - HI = LO = 0; counter 0
- Single-cycle ops: accept at edge N; `out_valid` high in cycle N+1; `in_ready` low in cycle N+1, high again in N+2. Back-to-back issue rate is 1 per 2 cycles.
- MD ops: accept at edge N; BUSY for cycles N+1..N+WIDTH; DONE (`out_valid`) in cycle N+WIDTH+1. Latency is WIDTH+1.
- `in_valid` is ignored while `in_ready` is low. No abort exists.
- MFHI/MFLO issued right after DONE return the updated HI/LO.
- Reset mid-BUSY: returns to IDLE and clears HI/LO. No `out_valid` pulse is produced.
- `result`/flags hold their last values when `out_valid` is low.

## Structure
- Package `alu_md_pkg`: op-code localparams, FSM state enum, `OP_IS_MD` helper function.
- Sub-module `md_unit`: iterative multiply/divide datapath with counter, operand/remainder shift registers, and sign fix-up. It has its own `start`/`done` and exposes {hi, lo, dbz}. `alu_md` holds the FSM, the logic ops, and the HI/LO registers.

## Test plan
- Reset mid-MULT (assert `rst_n` low at cycle 10) → IDLE immediately, `in_ready` = 1, HI = LO = 0, no `out_valid`.
- ADD 0x7FFFFFFF + 1 → `result` 0x80000000, `ovf` 1, pulse one cycle after accept. SUB 5 − 5 → 0, `zero` 1.
- SLT 0x80000000, 1 → 1. SLTU same operands → 0. SLT 3, 3 → 0.
- MULT 0xFFFFFFFF (−1) × 7 → HI 0xFFFFFFFF, LO 0xFFFFFFF9, pulse exactly 33 cycles after accept. MULTU same operands → HI 6, LO 0xFFFFFFF9. MFHI afterwards → 6.
- DIV −7 ÷ 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIVU 7 ÷ 0 → LO 0xFFFFFFFF, HI 7, `div_by_zero` 1.
- Hold `in_valid` high with new ops while BUSY → none are accepted, and the first op is taken in the cycle after DONE.
